// File: rtl/wb_spi_slave.sv
// Wishbone SPI slave (mode 0, MSB first, 8-bit words) with single-byte RX/TX buffers.
// Optional interrupt logic is enabled by defining SPI_SLAVE_IRQ_EN.
`timescale 1ns/1ps

module wb_spi_slave #(
  parameter int          sync_stages = 2,
  parameter logic [7:0]  dummy_byte  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        spi_ss_n,
  output logic        intr
);

  logic [sync_stages-1:0] r_sck_sync;
  logic [sync_stages-1:0] r_mosi_sync;
  logic [sync_stages-1:0] r_ss_sync;
  logic                   r_sck_prev;
  logic                   r_ss_prev;

  logic        r_ack;
  logic [31:0] r_dat;
  logic [7:0]  r_rx_data;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_tx_buf;
  logic [7:0]  r_tx_shift;
  logic        r_rx_full;
  logic        r_tx_full;
  logic        r_overrun;
  logic        r_active;
  logic [2:0]  r_bit_cnt;

  logic        w_sck;
  logic        w_mosi;
  logic        w_ss;
  logic        w_rise;
  logic        w_fall;
  logic        w_ss_start;
  logic        w_ss_end;
  logic        w_req;
  logic        w_rx_read;
  logic        w_tx_write;
  logic        w_ctrl_write;
  logic        w_byte_done;
  logic        w_tx_load;
  logic        w_ien;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_sck  = r_sck_sync[sync_stages-1];
  assign w_mosi = r_mosi_sync[sync_stages-1];
  assign w_ss   = r_ss_sync[sync_stages-1];

  assign w_rise     = w_sck & ~r_sck_prev;
  assign w_fall     = ~w_sck & r_sck_prev;
  // The ss synchronizer resets to "selected", so a frame can only start after ss_n
  // has been seen high following reset.
  assign w_ss_start = r_ss_prev & ~w_ss;
  assign w_ss_end   = ~r_ss_prev & w_ss;

  assign w_req        = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_rx_read    = w_req & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
  assign w_tx_write   = w_req &  wb_we_i & (wb_adr_i[3:2] == 2'd1);
  assign w_ctrl_write = w_req &  wb_we_i & (wb_adr_i[3:2] == 2'd3);

  assign w_byte_done = r_active & ~w_ss_start & ~w_ss_end & w_rise & (r_bit_cnt == 3'd7);
  assign w_tx_load   = w_ss_start | w_byte_done;

  assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8]};

`ifdef SPI_SLAVE_IRQ_EN
  logic r_ien;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ien <= 1'b0;
    end else if (w_ctrl_write) begin
      r_ien <= wb_dat_i[0];
    end
  end

  assign w_ien = r_ien;
  assign intr  = r_ien & (r_rx_full | r_overrun);
`else
  assign w_ien = 1'b0;
  assign intr  = 1'b0;
`endif

  always_comb begin
    w_rd_data = 32'd0;
    case (wb_adr_i[3:2])
      2'd0:    w_rd_data = {24'd0, r_rx_data};
      2'd2:    w_rd_data = {28'd0, r_active, r_overrun, r_tx_full, r_rx_full};
      2'd3:    w_rd_data = {31'd0, w_ien};
      default: w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '0;
      r_sck_prev  <= 1'b0;
      r_ss_prev   <= 1'b0;
      r_ack       <= 1'b0;
      r_dat       <= 32'd0;
      r_rx_data   <= 8'd0;
      r_rx_shift  <= 8'd0;
      r_tx_buf    <= 8'd0;
      r_tx_shift  <= dummy_byte;
      r_rx_full   <= 1'b0;
      r_tx_full   <= 1'b0;
      r_overrun   <= 1'b0;
      r_active    <= 1'b0;
      r_bit_cnt   <= 3'd0;
    end else begin
      r_sck_sync  <= {r_sck_sync[sync_stages-2:0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[sync_stages-2:0], spi_mosi};
      r_ss_sync   <= {r_ss_sync[sync_stages-2:0], spi_ss_n};
      r_sck_prev  <= w_sck;
      r_ss_prev   <= w_ss;

      // Read data and side effects are both taken in the request cycle, so they
      // become visible together in the ack cycle.
      r_ack <= w_req;
      r_dat <= (w_req & ~wb_we_i) ? w_rd_data : 32'd0;

      if (w_ss_start) begin
        r_active  <= 1'b1;
        r_bit_cnt <= 3'd0;
      end else if (w_ss_end) begin
        r_active  <= 1'b0;
        r_bit_cnt <= 3'd0;
      end else if (r_active) begin
        if (w_rise) begin
          r_rx_shift <= {r_rx_shift[6:0], w_mosi};
          r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
        if (w_fall && (r_bit_cnt != 3'd0)) begin
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
      end

      if (w_rx_read) begin
        r_rx_full <= 1'b0;
      end
      if (w_ctrl_write && wb_dat_i[1]) begin
        r_overrun <= 1'b0;
      end
      if (w_byte_done) begin
        if (!r_rx_full || w_rx_read) begin
          r_rx_data <= {r_rx_shift[6:0], w_mosi};
          r_rx_full <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end

      // A load sees the buffer as it was before any write in the same cycle.
      if (w_tx_load) begin
        r_tx_shift <= r_tx_full ? r_tx_buf : dummy_byte;
        if (r_tx_full) begin
          r_tx_full <= 1'b0;
        end
      end
      if (w_tx_write) begin
        r_tx_buf  <= wb_dat_i[7:0];
        r_tx_full <= 1'b1;
      end
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign spi_miso = r_active ? r_tx_shift[7] : 1'b1;

endmodule
